// File: rtl/fetch_pkg.sv
// Shared fetch types and constants: FSM states, instruction width, reset PC, branch opcodes.
// Also holds the branch-offset helper used by next_pc_calc.
package fetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Opcodes shared with the control unit.
  localparam logic [5:0]  OP_BEQ = 6'b000100;
  localparam logic [5:0]  OP_BNE = 6'b000101;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1,
    ERR  = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch bundle: instruction-memory req/ack on one side, decode/control handoff on the other.
// The master modport is the fetch unit; the slave modport is memory plus datapath.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               pc_src;
  logic [31:0]        pc;
  logic [31:0]        pc_plus4;
  logic               fetch_err;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, fetch_err,
    input  imem_ack, imem_rdata, instr_ready, pc_src
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, fetch_err,
    output imem_ack, imem_rdata, instr_ready, pc_src
  );

endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC: sequential pc+4, or pc+4 plus the word-scaled signed 16-bit offset.
// All arithmetic wraps modulo 2^32.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [15:0] i_imm16,
  input  logic        i_pc_src,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_pc_next
);

  logic [31:0] w_target;

  assign o_pc_plus4 = i_pc + 32'd4;
  assign w_target   = o_pc_plus4 + branch_offset(i_imm16);
  assign o_pc_next  = i_pc_src ? w_target : o_pc_plus4;

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter plus single-outstanding instruction fetch; at least 2 cycles per instruction.
// Holds the fetched word until instr_ready; a memory silent for TIMEOUT REQ cycles locks into ERR.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus
);

  localparam logic [31:0]      PC_INIT  = {RESET_PC[31:2], 2'b00};
  localparam bit               WD_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : '0;

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [31:0]        r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_load_instr;
  logic               w_load_pc;
  logic               w_timeout;
  logic [31:0]        w_pc_plus4;
  logic [31:0]        w_pc_next;

  next_pc_calc u_next_pc (
    .i_pc       (r_pc),
    .i_imm16    (r_instr[15:0]),
    .i_pc_src   (bus.pc_src),
    .o_pc_plus4 (w_pc_plus4),
    .o_pc_next  (w_pc_next)
  );

  assign w_timeout = WD_EN && (r_cnt == CNT_LAST);

  // An ack on the last watchdog cycle takes priority over the timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_load_instr = 1'b0;
    w_load_pc    = 1'b0;
    case (r_state)
      REQ: begin
        if (bus.imem_ack) begin
          w_load_instr = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = HOLD;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_timeout) begin
            w_state_nxt = ERR;
          end
        end
      end
      HOLD: begin
        if (bus.instr_ready) begin
          w_load_pc   = 1'b1;
          w_state_nxt = REQ;
        end
      end
      ERR:     w_state_nxt = ERR;
      default: w_state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= REQ;
      r_pc    <= PC_INIT;
      r_instr <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load_instr) begin
        r_instr <= bus.imem_rdata;
      end
      if (w_load_pc) begin
        r_pc <= w_pc_next;
      end
    end
  end

  assign bus.imem_req    = (r_state == REQ);
  assign bus.imem_addr   = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = (r_state == HOLD);
  assign bus.pc          = r_pc;
  assign bus.pc_plus4    = w_pc_plus4;
  assign bus.fetch_err   = (r_state == ERR);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench: unit A (RESET_PC=0, TIMEOUT=8) covers fetch, branches, watchdog and resets;
// unit B (RESET_PC=0xFFFF_FFFC, watchdog off) covers PC wrap and a long ack-less wait.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if a_if ();
  instr_fetch_unit_if b_if ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(8), .CNT_W(16)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(0), .CNT_W(16)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch_a(input int wait_cyc, input logic [31:0] data);
    repeat (wait_cyc) @(negedge clk);
    a_if.imem_ack   = 1'b1;
    a_if.imem_rdata = data;
    @(negedge clk);
    a_if.imem_ack   = 1'b0;
    a_if.imem_rdata = 32'h0;
  endtask

  task automatic consume_a(input logic src);
    a_if.instr_ready = 1'b1;
    a_if.pc_src      = src;
    @(negedge clk);
    a_if.instr_ready = 1'b0;
    a_if.pc_src      = 1'b0;
  endtask

  task automatic seq_a(input int n);
    repeat (n) begin
      fetch_a(0, 32'h0000_0000);
      consume_a(1'b0);
    end
  endtask

  initial begin
    a_if.imem_ack = 1'b0; a_if.imem_rdata = '0; a_if.instr_ready = 1'b0; a_if.pc_src = 1'b0;
    b_if.imem_ack = 1'b0; b_if.imem_rdata = '0; b_if.instr_ready = 1'b0; b_if.pc_src = 1'b0;

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pc",       a_if.pc,                 32'h0);
    chk("rst_instr",    a_if.instr,              32'h0);
    chk("rst_valid",    32'(a_if.instr_valid),   32'h0);
    chk("rst_err",      32'(a_if.fetch_err),     32'h0);
    chk("rst_req",      32'(a_if.imem_req),      32'h1);
    chk("rst_b_pc",     b_if.pc,                 32'hFFFF_FFFC);
    chk("rst_b_plus4",  b_if.pc_plus4,           32'h0);

    // First fetch, ack on the third REQ cycle
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("first_req",  32'(a_if.imem_req),   32'h1);
      chk("first_addr", a_if.imem_addr,       32'h0);
      chk("first_vld0", 32'(a_if.instr_valid), 32'h0);
      if (i == 2) begin
        a_if.imem_ack   = 1'b1;
        a_if.imem_rdata = 32'h8C08_0004;
      end
    end
    @(negedge clk);
    a_if.imem_ack = 1'b0; a_if.imem_rdata = '0;
    chk("first_valid", 32'(a_if.instr_valid), 32'h1);
    chk("first_instr", a_if.instr,            32'h8C08_0004);
    chk("first_pc",    a_if.pc,               32'h0);
    chk("first_plus4", a_if.pc_plus4,         32'h4);
    chk("first_req0",  32'(a_if.imem_req),    32'h0);

    // Sequential advance
    consume_a(1'b0);
    chk("seq_req",   32'(a_if.imem_req),    32'h1);
    chk("seq_addr",  a_if.imem_addr,        32'h4);
    chk("seq_vld0",  32'(a_if.instr_valid), 32'h0);

    // Stall 20 cycles in HOLD; stray ack and pc_src must have no effect
    fetch_a(0, 32'h2001_0001);
    a_if.imem_ack = 1'b1; a_if.imem_rdata = 32'hDEAD_BEEF; a_if.pc_src = 1'b1;
    repeat (20) begin
      chk("hold_instr", a_if.instr,            32'h2001_0001);
      chk("hold_pc",    a_if.pc,               32'h4);
      chk("hold_valid", 32'(a_if.instr_valid), 32'h1);
      chk("hold_err",   32'(a_if.fetch_err),   32'h0);
      @(negedge clk);
    end
    a_if.imem_ack = 1'b0; a_if.imem_rdata = '0; a_if.pc_src = 1'b0;
    consume_a(1'b0);
    chk("after_hold_addr", a_if.imem_addr, 32'h8);
    fetch_a(1, 32'h0);
    consume_a(1'b0);
    seq_a(1);
    chk("walk_addr_10", a_if.imem_addr, 32'h10);

    // Backward branch taken: 0x10 + 4 - 16 = 0x4
    fetch_a(0, 32'h1109_FFFC);
    chk("br_pc",    a_if.pc,       32'h10);
    chk("br_plus4", a_if.pc_plus4, 32'h14);
    consume_a(1'b1);
    chk("br_back_addr", a_if.imem_addr, 32'h4);

    // Backward branch wrapping below zero: 0x4 + 4 - 16 = 0xFFFF_FFF8
    fetch_a(0, 32'h1109_FFFC);
    consume_a(1'b1);
    chk("br_wrap_addr", a_if.imem_addr, 32'hFFFF_FFF8);

    // Forward bne wrapping past the top: 0xFFFF_FFF8 + 4 + 12 = 0x8
    fetch_a(0, {OP_BNE, 26'h109_0003});
    chk("bne_instr", a_if.instr, 32'h1509_0003);
    consume_a(1'b1);
    chk("br_fwd_addr", a_if.imem_addr, 32'h8);

    // Same branch word at 0x10 but not taken -> 0x14
    seq_a(2);
    chk("walk2_addr_10", a_if.imem_addr, 32'h10);
    fetch_a(0, {OP_BEQ, 26'h109_FFFC});
    consume_a(1'b0);
    chk("br_nt_addr", a_if.imem_addr, 32'h14);

    // Reset during REQ at 0x20 with an ack pending
    seq_a(3);
    chk("mid_req_addr", a_if.imem_addr, 32'h20);
    a_if.imem_ack = 1'b1; a_if.imem_rdata = 32'hAAAA_AAAA;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_pc",    a_if.pc,               32'h0);
    chk("rst_req_instr", a_if.instr,            32'h0);
    chk("rst_req_valid", 32'(a_if.instr_valid), 32'h0);
    @(negedge clk);
    a_if.imem_ack = 1'b0; a_if.imem_rdata = '0;
    rst_n = 1'b1;
    chk("refetch_req",  32'(a_if.imem_req), 32'h1);
    chk("refetch_addr", a_if.imem_addr,     32'h0);

    // Reset during HOLD
    fetch_a(0, 32'h1234_5678);
    chk("mid_hold_valid", 32'(a_if.instr_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", 32'(a_if.instr_valid), 32'h0);
    chk("rst_hold_instr", a_if.instr,            32'h0);
    chk("rst_hold_pc",    a_if.pc,               32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Watchdog: ack on the 8th REQ cycle wins
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) @(negedge clk);
      chk("wd_ack_req", 32'(a_if.imem_req),  32'h1);
      chk("wd_ack_err", 32'(a_if.fetch_err), 32'h0);
      if (i == 8) begin
        a_if.imem_ack = 1'b1; a_if.imem_rdata = 32'h5555_0001;
      end
    end
    @(negedge clk);
    a_if.imem_ack = 1'b0; a_if.imem_rdata = '0;
    chk("wd_late_valid", 32'(a_if.instr_valid), 32'h1);
    chk("wd_late_err",   32'(a_if.fetch_err),   32'h0);
    chk("wd_late_instr", a_if.instr,            32'h5555_0001);
    consume_a(1'b0);

    // Watchdog: no ack for 8 REQ cycles
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) @(negedge clk);
      chk("wd_req",     32'(a_if.imem_req),  32'h1);
      chk("wd_err_low", 32'(a_if.fetch_err), 32'h0);
    end
    @(negedge clk);
    chk("wd_err",    32'(a_if.fetch_err),   32'h1);
    chk("wd_req0",   32'(a_if.imem_req),    32'h0);
    chk("wd_valid0", 32'(a_if.instr_valid), 32'h0);
    a_if.imem_ack = 1'b1; a_if.imem_rdata = 32'h7777_7777;
    repeat (3) begin
      @(negedge clk);
      chk("err_sticky",    32'(a_if.fetch_err),   32'h1);
      chk("err_req0",      32'(a_if.imem_req),    32'h0);
      chk("err_ack_ignor", 32'(a_if.instr_valid), 32'h0);
    end
    a_if.imem_ack = 1'b0; a_if.imem_rdata = '0;

    // Unit B: watchdog disabled, then wrap from 0xFFFF_FFFC
    chk("b_no_err", 32'(b_if.fetch_err), 32'h0);
    chk("b_req",    32'(b_if.imem_req),  32'h1);
    chk("b_addr",   b_if.imem_addr,      32'hFFFF_FFFC);
    b_if.imem_ack = 1'b1; b_if.imem_rdata = 32'h0000_0010;
    @(negedge clk);
    b_if.imem_ack = 1'b0; b_if.imem_rdata = '0;
    chk("b_valid", 32'(b_if.instr_valid), 32'h1);
    chk("b_plus4", b_if.pc_plus4,         32'h0);
    b_if.instr_ready = 1'b1;
    @(negedge clk);
    b_if.instr_ready = 1'b0;
    chk("b_wrap_addr", b_if.imem_addr,     32'h0);
    chk("b_wrap_req",  32'(b_if.imem_req), 32'h1);

    // Reset clears a latched error
    #2 rst_n = 1'b0;
    #1;
    chk("rst_err_clr", 32'(a_if.fetch_err), 32'h0);
    chk("rst_err_req", 32'(a_if.imem_req),  32'h1);
    chk("rst_b_pc2",   b_if.pc,             32'hFFFF_FFFC);
    @(negedge clk);
    rst_n = 1'b1;
    chk("restart_addr", a_if.imem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the single-cycle control unit. Holds the program counter and fetches instructions from instruction memory over a req/ack handshake.
- Presents one instruction at a time to decode/control.
- On consume, takes the control unit's branch decision (pc_src) and computes the next PC: sequential, or branch target from the instruction's own 16-bit immediate.
- Fetch timeout watchdog flags a dead memory.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address; must be word-aligned (bits 1:0 = 0).
- TIMEOUT, 16, max cycles in REQ without imem_ack before error; 0 disables the watchdog.
- CNT_W, 16, width of the timeout counter; TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  32  fetch address (= pc)
- imem_ack  in  1  memory returns data this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- instr  out  32  current instruction to decode/control
- instr_valid  out  1  instr and pc are valid
- instr_ready  in  1  datapath consumes the instruction this cycle
- pc_src  in  1  branch taken (from control unit), sampled with instr_ready
- pc  out  32  address of current instruction
- pc_plus4  out  32  pc + 4, for the datapath
- fetch_err  out  1  sticky watchdog error

Behaviour:
- States: REQ, HOLD, ERR. Reset state is REQ.
- Registered outputs. Reset values:
  - pc = RESET_PC
  - instr = 0
  - instr_valid = 0
  - fetch_err = 0
  - timeout counter = 0
- REQ:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - imem_ack=1 → instr <= imem_rdata, counter cleared, next state HOLD.
  - Otherwise counter increments.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 with no ack → ERR. The ack cycle wins over the timeout when both fall on the same edge.
- HOLD:
  - imem_req=0, instr_valid=1; instr and pc stable.
  - instr_ready=1 → update pc and go to REQ. instr_valid falls on the next cycle.
  - pc_src=0: pc <= pc + 4.
  - pc_src=1: pc <= pc + 4 + (sign_extend(instr[15:0]) << 2).
  - instr_ready=0 → hold indefinitely; no watchdog counting.
- ERR:
  - imem_req=0, instr_valid=0, fetch_err=1.
  - Exit only via rst_n.
- imem_ack is ignored outside REQ.
- pc_src is ignored unless instr_valid & instr_ready.
- Latency: minimum 2 cycles per instruction (ack on the first REQ cycle, ready on the first HOLD cycle).
- Arithmetic is modulo 2^32:
  - 0xFFFF_FFFC + 4 = 0x0000_0000.
  - Backward branches wrap below 0.
- Word alignment is preserved by construction; bits 1:0 of pc are always 0.
- pc_plus4 is combinational from the pc register.
- Reset asserted in any state (including mid-REQ with an ack pending) immediately forces the reset values. The first REQ cycle after rst_n rises re-fetches RESET_PC.
- No speculative prefetch; exactly one outstanding request.

Decomposition:
- Shared package fetch_pkg:
  - state enum {REQ, HOLD, ERR}
  - INSTR_W=32
  - default RESET_PC
  - opcode constants shared with the control unit (beq 6'b000100, bne 6'b000101), for benches.
- One natural sub-module: next_pc_calc. Combinational; inputs pc, imm16, pc_src; outputs pc_plus4 and pc_next. Reused later by the pipelined datapath.

Test Plan:
- Reset and first fetch:
  - Stimulus: rst_n low then high; imem_ack on the 3rd REQ cycle with rdata=0x8C08_0004.
  - Response: imem_req=1, imem_addr=0x0 throughout REQ; next cycle instr_valid=1, instr=0x8C08_0004, pc=0x0, pc_plus4=0x4.
- Sequential advance:
  - Stimulus: in HOLD, instr_ready=1, pc_src=0.
  - Response: next cycle imem_req=1, imem_addr=0x4, instr_valid=0.
  - Also hold instr_ready=0 for 20 cycles: instr and pc stay stable, fetch_err=0.
- Branch taken, backward:
  - Stimulus: pc=0x10, instr=0x1109_FFFC, instr_ready=1, pc_src=1.
  - Response: imem_addr=0x0000_0004.
  - Same with pc_src=0 → imem_addr=0x14.
- Wrap-around:
  - Stimulus: RESET_PC=0xFFFF_FFFC, fetch, then ready with pc_src=0.
  - Response: imem_addr=0x0000_0000.
- Watchdog:
  - Stimulus: TIMEOUT=8, never ack.
  - Response: fetch_err=1 and imem_req=0 after 8 REQ cycles; both stay there.
  - Ack arriving in the 8th cycle → HOLD, no error.
  - Late acks after ERR are ignored.
- Reset mid-operation:
  - Stimulus: assert rst_n low during REQ (addr 0x20) and during HOLD.
  - Response: asynchronously pc=RESET_PC, instr_valid=0, instr=0, fetch_err cleared; fetch restarts at RESET_PC.
